// File: rtl/shift_sequencer_pkg.sv
// Shared ALU shift-path definitions.
// Holds the sequencer state encoding, the step sizes of the two shift
// stages and the direction encoding used by both the stages and the
// sequencer.
package shift_sequencer_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  localparam int SHIFT_STEP_COARSE = 4;
  localparam int SHIFT_STEP_FINE   = 1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shifter32b1.sv
// Combinational shift-by-1 stage, same port contract as shifter32b4.
// Ports:
//   out      - shifted word (equals in when shift = 0)
//   in       - operand
//   shiftdir - DIR_LEFT / DIR_RIGHT
//   shift    - enable; 0 passes the operand through
//   shifta   - arithmetic fill on right shifts (ignored on left)
module shifter32b1
  import shift_sequencer_pkg::*;
(
  output logic [31:0] out,
  input  logic [31:0] in,
  input  logic        shiftdir,
  input  logic        shift,
  input  logic        shifta
);

  logic fill;

  assign fill = shifta & in[31];

  always_comb begin
    out = in;
    if (shift) begin
      if (shiftdir == DIR_LEFT) out = {in[30:0], 1'b0};
      else                      out = {fill, in[31:1]};
    end
  end

endmodule

// File: rtl/shifter32b4.sv
// Combinational shift-by-4 stage.
// Ports:
//   out      - shifted word (equals in when shift = 0)
//   in       - operand
//   shiftdir - DIR_LEFT / DIR_RIGHT
//   shift    - enable; 0 passes the operand through
//   shifta   - arithmetic fill on right shifts (ignored on left)
module shifter32b4
  import shift_sequencer_pkg::*;
(
  output logic [31:0] out,
  input  logic [31:0] in,
  input  logic        shiftdir,
  input  logic        shift,
  input  logic        shifta
);

  logic fill;

  assign fill = shifta & in[31];

  always_comb begin
    out = in;
    if (shift) begin
      if (shiftdir == DIR_LEFT) out = {in[27:0], 4'b0000};
      else                      out = {{4{fill}}, in[31:4]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shift unit. A request is latched on the input
// handshake, then shifted by 4 while at least 4 remain and by 1 for the
// remainder, one step per clock. The result is presented on the output
// handshake and held until accepted.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - request handshake
//   in_data, in_amt      - operand and shift amount (0..31)
//   in_dir, in_arith     - direction (1 = left), sign-fill on right shifts
//   out_valid / out_ready- result handshake
//   out_data             - shifted result
//   busy                 - an operation is in flight or awaiting pickup
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int AMT_W_P = AMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_P-1:0] in_data,
  input  logic [AMT_W_P-1:0] in_amt,
  input  logic               in_dir,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_P-1:0] out_data,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [WIDTH_P-1:0] data_q, data_d;
  logic [AMT_W_P-1:0] rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               arith_q, arith_d;

  logic               step_coarse, step_fine;
  logic [WIDTH_P-1:0] shift4_out, shift1_out;

  localparam logic [AMT_W_P-1:0] COARSE = AMT_W_P'(SHIFT_STEP_COARSE);
  localparam logic [AMT_W_P-1:0] FINE   = AMT_W_P'(SHIFT_STEP_FINE);

  // Only one stage is enabled per cycle; the other passes through and is
  // not selected by the step mux below.
  assign step_coarse = (state_q == SHIFT) && (rem_q >= COARSE);
  assign step_fine   = (state_q == SHIFT) && !step_coarse && (rem_q != '0);

  shifter32b4 u_shift4 (
    .out      (shift4_out),
    .in       (data_q),
    .shiftdir (dir_q),
    .shift    (step_coarse),
    .shifta   (arith_q)
  );

  shifter32b1 u_shift1 (
    .out      (shift1_out),
    .in       (data_q),
    .shiftdir (dir_q),
    .shift    (step_fine),
    .shifta   (arith_q)
  );

  // NOTE: every signal assigned here gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_amt;
          dir_d   = in_dir;
          arith_d = in_arith;
          state_d = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (step_coarse) begin
          data_d = shift4_out;
          rem_d  = rem_q - COARSE;
        end else if (step_fine) begin
          data_d = shift1_out;
          rem_d  = rem_q - FINE;
        end
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer. Expected results and latencies
// are pushed to a scoreboard queue when a request is issued and popped
// when the result appears.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_shift(input logic [31:0] d, input int amt,
                                              input logic dir, input logic arith);
    if (dir)        return d << amt;
    else if (arith) return 32'($signed(d) >>> amt);
    else            return d >> amt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, records its expected result, and steps past the
  // accept edge so the caller lands in cycle 1.
  task automatic issue(input logic [31:0] d, input int amt, input logic dir,
                       input logic arith);
    exp_t e;
    e.data = model_shift(d, amt, dir, arith);
    e.lat  = amt / 4 + amt % 4 + 1;
    sb.push_back(e);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = 5'(amt);
    in_dir   = dir;
    in_arith = arith;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 5'($urandom);
  endtask

  // Waits for out_valid, bounded; reports the cycle it appeared in and
  // whether in_ready was seen high while waiting.
  task automatic wait_result(output int lat, output bit ready_hi, output bit timed_out);
    lat       = 1;
    ready_hi  = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) ready_hi = 1'b1;
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    in_arith  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    tick();
    vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_left_max();
    int lat; bit rhi, to; exp_t e;
    issue(32'h0000_0001, 31, 1'b1, 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL left_max_busy got=%b want=1", busy); end
    wait_result(lat, rhi, to);
    e = sb.pop_front();
    vectors++; if (to) begin miscompares++; $display("FAIL left_max_timeout no out_valid within 40 cycles"); end
    vectors++; if (lat !== e.lat || lat !== 11) begin miscompares++; $display("FAIL left_max_latency got=%0d want=11", lat); end
    vectors++; if (out_data !== e.data || out_data !== 32'h8000_0000) begin miscompares++; $display("FAIL left_max_data got=%h want=80000000", out_data); end
    vectors++; if (rhi !== 1'b0) begin miscompares++; $display("FAIL left_max_in_ready high during cycles 1..11 got=1 want=0"); end
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL left_max_ready_after got=%b want=1", in_ready); end
  endtask

  task automatic test_right_arith();
    int lat; bit rhi, to; exp_t e;
    logic [31:0] want[2];
    want[0] = 32'hFC00_0000;
    want[1] = 32'h0400_0000;
    for (int k = 0; k < 2; k++) begin
      issue(32'h8000_0000, 5, 1'b0, (k == 0));
      wait_result(lat, rhi, to);
      e = sb.pop_front();
      vectors++; if (to || lat !== 3 || lat !== e.lat) begin miscompares++; $display("FAIL right_a%0d_latency got=%0d timeout=%b want=3", 1 - k, lat, to); end
      vectors++; if (out_data !== e.data || out_data !== want[k]) begin miscompares++; $display("FAIL right_a%0d_data got=%h want=%h", 1 - k, out_data, want[k]); end
      tick();
    end
  endtask

  task automatic test_right_logical();
    int lat; bit rhi, to; exp_t e;
    issue(32'hF000_0000, 8, 1'b0, 1'b0);
    wait_result(lat, rhi, to);
    e = sb.pop_front();
    vectors++; if (to || lat !== 3 || lat !== e.lat) begin miscompares++; $display("FAIL right_log_latency got=%0d timeout=%b want=3", lat, to); end
    vectors++; if (out_data !== e.data || out_data !== 32'h00F0_0000) begin miscompares++; $display("FAIL right_log_data got=%h want=00f00000", out_data); end
    tick();
  endtask

  task automatic test_zero_backpressure();
    int lat; bit rhi, to; exp_t e;
    out_ready = 1'b0;
    issue(32'h1234_5678, 0, 1'b1, 1'b0);
    wait_result(lat, rhi, to);
    e = sb.pop_front();
    vectors++; if (to || lat !== 1 || lat !== e.lat) begin miscompares++; $display("FAIL zero_latency got=%0d timeout=%b want=1", lat, to); end
    for (int c = 0; c < 4; c++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== e.data || in_ready !== 1'b0) begin
        miscompares++; $display("FAIL zero_hold_c%0d valid=%b data=%h ready=%b want 1/12345678/0", c, out_valid, out_data, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL zero_still_valid got=%b want=1", out_valid); end
    tick();
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_release ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_op();
    int lat; bit rhi, to; exp_t e;
    bit saw_valid;
    saw_valid = 1'b0;
    issue(32'h0000_FFFF, 20, 1'b1, 1'b0);
    for (int c = 1; c < 3; c++) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    if (out_valid) saw_valid = 1'b1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    tick();
    rst_n = 1'b1;
    vectors++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL midreset_state ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid);
    end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL midreset_data got=%h want=00000000", out_data); end
    for (int c = 0; c < 3; c++) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    vectors++; if (saw_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid_pulse got=1 want=0"); end
    issue(32'h0000_0001, 4, 1'b1, 1'b0);
    wait_result(lat, rhi, to);
    e = sb.pop_front();
    vectors++; if (to || lat !== 2 || lat !== e.lat) begin miscompares++; $display("FAIL after_reset_latency got=%0d timeout=%b want=2", lat, to); end
    vectors++; if (out_data !== 32'h0000_0010) begin miscompares++; $display("FAIL after_reset_data got=%h want=00000010", out_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat; bit rhi, to; exp_t e;
    logic [31:0] d;
    int amt;
    logic dir, arith;
    for (int n = 0; n < 12; n++) begin
      d     = $urandom;
      amt   = $urandom_range(0, 31);
      dir   = 1'($urandom);
      arith = 1'($urandom);
      if (n == 0) begin d = 32'h8765_4321; amt = 3; dir = 1'b0; arith = 1'b1; end
      issue(d, amt, dir, arith);
      wait_result(lat, rhi, to);
      e = sb.pop_front();
      vectors++; if (to || lat !== e.lat || rhi) begin
        miscompares++; $display("FAIL b2b_%0d_timing lat=%0d want=%0d timeout=%b ready_seen=%b", n, lat, e.lat, to, rhi);
      end
      vectors++; if (out_data !== e.data) begin
        miscompares++; $display("FAIL b2b_%0d_data d=%h amt=%0d dir=%b ar=%b got=%h want=%h", n, d, amt, dir, arith, out_data, e.data);
      end
      tick();
    end
    vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_left_max();
    test_right_arith();
    test_right_logical();
    test_zero_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
